// File: rtl/sb_sram_slv_pkg.sv
// Shared definitions for the SB SRAM slave: response codes and read-channel state encodings.
package sb_sram_slv_pkg;

    localparam logic SB_BRESP_OKAY = 1'b0;
    localparam logic SB_BRESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FIRST = 2'd1,
        R_HOLD  = 2'd2
    } rstate_e;

endpackage

// File: rtl/sb_sram_slv.sv
// SB slave mapping round-robin arbitrated read/write channels onto one single-port
// synchronous SRAM (1-cycle read latency), with a hold register for read backpressure.
module sb_sram_slv
    import sb_sram_slv_pkg::*;
#(
    parameter int AW      = 12,
    parameter int ERR_CHK = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sb_arvalid,
    output logic          sb_arready,
    input  logic [31:0]   sb_araddr,
    output logic          sb_rvalid,
    input  logic          sb_rready,
    output logic [31:0]   sb_rdata,
    input  logic          sb_wvalid,
    output logic          sb_wready,
    input  logic [31:0]   sb_waddr,
    input  logic [31:0]   sb_wdata,
    input  logic [3:0]    sb_wstrb,
    output logic          sb_bvalid,
    input  logic          sb_bready,
    output logic          sb_bresp,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_wben,
    input  logic [31:0]   sram_rdata
);

    // Bits [29:AW+2] must be zero; [31:30] were already decoded by the interconnect.
    localparam logic [31:0] OOR_MASK = 32'h3FFF_FFFF & ~((32'h1 << (AW + 2)) - 32'h1);

    function automatic logic addr_oor(input logic [31:0] a);
        return (ERR_CHK != 0) && ((a & OOR_MASK) != 32'h0);
    endfunction

    rstate_e     rstate_q, rstate_d;
    logic        prio_rd_q, prio_rd_d;
    logic        rd_err_q, rd_err_d;
    logic        bvalid_q, bvalid_d;
    logic        bresp_q, bresp_d;
    logic [31:0] hold_q, hold_d;

    logic r_free, w_free, contested;
    logic ar_ok, r_ok, w_ok, b_ok;
    logic ar_oor, w_oor;
    logic [31:0] first_data;

    assign sb_rvalid = (rstate_q != R_IDLE);
    assign sb_bvalid = bvalid_q;
    assign sb_bresp  = bresp_q;

    assign r_free = (rstate_q == R_IDLE) | r_ok;
    assign w_free = ~bvalid_q | b_ok;

    assign sb_arready = ~rst & r_free & (~sb_wvalid | ~w_free | prio_rd_q);
    assign sb_wready  = ~rst & w_free & (~sb_arvalid | ~r_free | ~prio_rd_q);

    assign ar_ok = sb_arvalid & sb_arready;
    assign r_ok  = sb_rvalid & sb_rready;
    assign w_ok  = sb_wvalid & sb_wready;
    assign b_ok  = bvalid_q & sb_bready;

    assign ar_oor    = addr_oor(sb_araddr);
    assign w_oor     = addr_oor(sb_waddr);
    assign contested = sb_arvalid & sb_wvalid & r_free & w_free;

    // Out-of-range reads never touched the SRAM, so its output is not theirs.
    assign first_data = rd_err_q ? 32'h0 : sram_rdata;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wben  = '0;
        if (w_ok) begin
            sram_ce    = ~w_oor;
            sram_we    = 1'b1;
            sram_addr  = sb_waddr[AW+1:2];
            sram_wdata = sb_wdata;
            sram_wben  = sb_wstrb;
        end else if (ar_ok) begin
            sram_ce   = ~ar_oor;
            sram_we   = 1'b0;
            sram_addr = sb_araddr[AW+1:2];
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        hold_d   = hold_q;
        sb_rdata = 32'h0;
        case (rstate_q)
            R_IDLE: begin
                if (ar_ok) rstate_d = R_FIRST;
            end
            R_FIRST: begin
                sb_rdata = first_data;
                if (r_ok) begin
                    rstate_d = ar_ok ? R_FIRST : R_IDLE;
                end else begin
                    rstate_d = R_HOLD;
                    hold_d   = first_data;
                end
            end
            R_HOLD: begin
                sb_rdata = hold_q;
                if (r_ok) rstate_d = ar_ok ? R_FIRST : R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        prio_rd_d = prio_rd_q;
        if (contested) prio_rd_d = ~ar_ok;
        rd_err_d = ar_ok ? ar_oor : rd_err_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (w_ok) begin
            bvalid_d = 1'b1;
            bresp_d  = w_oor ? SB_BRESP_ERR : SB_BRESP_OKAY;
        end else if (b_ok) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            prio_rd_q <= 1'b1;
            rd_err_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= SB_BRESP_OKAY;
        end else begin
            rstate_q  <= rstate_d;
            prio_rd_q <= prio_rd_d;
            rd_err_q  <= rd_err_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_sb_sram_slv.sv
// Randomized and directed bench for sb_sram_slv against a word-array reference model.
module tb_sb_sram_slv;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sb_arvalid, sb_arready;
    logic [31:0]   sb_araddr;
    logic          sb_rvalid, sb_rready;
    logic [31:0]   sb_rdata;
    logic          sb_wvalid, sb_wready;
    logic [31:0]   sb_waddr, sb_wdata;
    logic [3:0]    sb_wstrb;
    logic          sb_bvalid, sb_bready, sb_bresp;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [3:0]    sram_wben;
    logic [31:0]   sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    sb_sram_slv #(.AW(AW), .ERR_CHK(1)) dut (
        .clk(clk), .rst(rst),
        .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
        .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata),
        .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
        .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
        .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wben(sram_wben), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural SRAM the DUT drives.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wben[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: memory contents as seen by accepted SB transfers.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] rq[$];
    logic        bq[$];
    logic        nxt_rd;

    function automatic logic is_oor(input logic [31:0] a);
        return a[29:AW+2] != '0;
    endfunction

    always @(negedge clk) begin
        logic ar_ok, r_ok, w_ok, b_ok, r_free, w_free;
        logic [AW-1:0] idx;
        if (rst) begin
            rq.delete();
            bq.delete();
            nxt_rd = 1'b1;
        end else begin
            ar_ok  = sb_arvalid & sb_arready;
            r_ok   = sb_rvalid & sb_rready;
            w_ok   = sb_wvalid & sb_wready;
            b_ok   = sb_bvalid & sb_bready;
            r_free = ~sb_rvalid | sb_rready;
            w_free = ~sb_bvalid | sb_bready;

            chk("rvalid", {31'b0, sb_rvalid}, {31'b0, rq.size() != 0});
            if (sb_rvalid && rq.size() != 0) chk("rdata", sb_rdata, rq[0]);
            if (!sb_rvalid) chk("rdata_idle", sb_rdata, 32'h0);
            chk("bvalid", {31'b0, sb_bvalid}, {31'b0, bq.size() != 0});
            if (sb_bvalid && bq.size() != 0) chk("bresp", {31'b0, sb_bresp}, {31'b0, bq[0]});

            if (sb_arvalid && sb_wvalid && r_free && w_free) begin
                chk("one_grant", {31'b0, ar_ok ^ w_ok}, 32'd1);
                chk("rr_order", {31'b0, ar_ok}, {31'b0, nxt_rd});
                nxt_rd = ~ar_ok;
            end
            if (!r_free) chk("arready_busy", {31'b0, sb_arready}, 32'd0);
            if (r_free && !sb_wvalid) chk("arready_free", {31'b0, sb_arready}, 32'd1);
            if (!w_free) chk("wready_busy", {31'b0, sb_wready}, 32'd0);
            if (w_free && !sb_arvalid) chk("wready_free", {31'b0, sb_wready}, 32'd1);

            if (r_ok && rq.size() != 0) void'(rq.pop_front());
            if (b_ok && bq.size() != 0) void'(bq.pop_front());

            if (w_ok) begin
                idx = sb_waddr[AW+1:2];
                if (is_oor(sb_waddr)) begin
                    chk("w_oor_ce", {31'b0, sram_ce}, 32'd0);
                    bq.push_back(1'b1);
                end else begin
                    chk("w_ce", {31'b0, sram_ce}, 32'd1);
                    chk("w_we", {31'b0, sram_we}, 32'd1);
                    chk("w_addr", {20'b0, sram_addr}, {20'b0, idx});
                    chk("w_data", sram_wdata, sb_wdata);
                    chk("w_wben", {28'b0, sram_wben}, {28'b0, sb_wstrb});
                    for (int b = 0; b < 4; b++)
                        if (sb_wstrb[b]) ref_mem[idx][8*b +: 8] = sb_wdata[8*b +: 8];
                    bq.push_back(1'b0);
                end
            end else if (ar_ok) begin
                idx = sb_araddr[AW+1:2];
                chk("r_ce", {31'b0, sram_ce}, {31'b0, ~is_oor(sb_araddr)});
                chk("r_we", {31'b0, sram_we}, 32'd0);
                if (!is_oor(sb_araddr)) chk("r_addr", {20'b0, sram_addr}, {20'b0, idx});
                rq.push_back(is_oor(sb_araddr) ? 32'h0 : ref_mem[idx]);
            end else begin
                chk("ce_idle", {31'b0, sram_ce}, 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        sb_arvalid = 0; sb_araddr = 0; sb_wvalid = 0; sb_waddr = 0;
        sb_wdata = 0; sb_wstrb = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic ce_o, output logic bresp_o);
        int n;
        @(posedge clk); #1;
        sb_wvalid = 1; sb_waddr = a; sb_wdata = d; sb_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!sb_wready && n < 100) begin n++; @(negedge clk); end
        if (!sb_wready) chk("w_timeout", 32'd0, 32'd1);
        ce_o = sram_ce;
        @(posedge clk); #1;
        sb_wvalid = 0;
        @(negedge clk);
        chk("b_latency", {31'b0, sb_bvalid}, 32'd1);
        bresp_o = sb_bresp;
    endtask

    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!sb_arready && n < 100) begin n++; @(negedge clk); end
        if (!sb_arready) chk("ar_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        sb_arvalid = 1; sb_araddr = a;
        wait_ar();
        @(posedge clk); #1;
        sb_arvalid = 0;
        n = 0;
        @(negedge clk);
        while (!(sb_rvalid && sb_rready) && n < 100) begin n++; @(negedge clk); end
        if (!(sb_rvalid && sb_rready)) chk("r_timeout", 32'd0, 32'd1);
        d = sb_rdata;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom % 16) << 2;
        if ($urandom % 2 == 0) a = a | 32'hC000_0000;
        if ($urandom % 10 == 0) a = a | (32'h0000_4000 << ($urandom % 16));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        ce, br;
        int          nr, nw;

        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            sram_mem[i] = d;
            ref_mem[i]  = d;
        end
        sram_rdata = 0;
        rst = 1; sb_rready = 1; sb_bready = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {31'b0, sb_rvalid}, 32'd0);
        chk("rst_bvalid", {31'b0, sb_bvalid}, 32'd0);
        chk("rst_bresp", {31'b0, sb_bresp}, 32'd0);
        chk("rst_rdata", sb_rdata, 32'h0);
        chk("rst_ce", {31'b0, sram_ce}, 32'd0);
        chk("rst_we", {31'b0, sram_we}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Basic write then read-back
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, ce, br);
        chk("wr_bresp", {31'b0, br}, 32'd0);
        do_read(32'h0000_0010, d);
        chk("rd_basic", d, 32'hDEAD_BEEF);

        // Read held under backpressure while the same word is overwritten
        @(posedge clk); #1;
        sb_rready = 0; sb_arvalid = 1; sb_araddr = 32'h0000_0010;
        wait_ar();
        @(posedge clk); #1;
        sb_arvalid = 0;
        for (int i = 0; i < 5; i++) do_write(32'h0000_0010, $urandom, 4'hF, ce, br);
        @(posedge clk); #1;
        sb_rready = 1;
        @(negedge clk);
        chk("hold_rdata", sb_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold_done", {31'b0, sb_rvalid}, 32'd0);

        // Contested channels alternate, read first after reset
        do_reset();
        @(posedge clk); #1;
        sb_arvalid = 1; sb_araddr = 32'h0000_0040;
        sb_wvalid = 1; sb_waddr = 32'h0000_0044; sb_wdata = 32'h1234_5678; sb_wstrb = 4'hF;
        nr = 0; nw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_grant_rd", {31'b0, sb_arready}, 32'd1);
            if (sb_arvalid && sb_arready) nr++;
            if (sb_wvalid && sb_wready) nw++;
        end
        @(posedge clk); #1;
        idle_inputs();
        chk("alt_reads", nr, 32'd4);
        chk("alt_writes", nw, 32'd4);

        // Back-to-back reads
        for (int i = 0; i < 6; i++) do_write(32'h100 + 4 * i, $urandom, 4'hF, ce, br);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sb_arvalid = 1; sb_araddr = 32'h100 + 4 * i;
            @(negedge clk);
            chk("b2b_arready", {31'b0, sb_arready}, 32'd1);
        end
        @(posedge clk); #1;
        sb_arvalid = 0;

        // Byte-lane write
        do_write(32'h0000_0020, 32'h1122_3344, 4'hF, ce, br);
        do_write(32'h0000_0020, 32'h0000_AB00, 4'b0010, ce, br);
        do_read(32'h0000_0020, d);
        chk("byte_merge", d, 32'h1122_AB44);

        // Zero strobe: access with no lanes, OKAY response
        do_write(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, ce, br);
        chk("wstrb0_ce", {31'b0, ce}, 32'd1);
        chk("wstrb0_bresp", {31'b0, br}, 32'd0);
        do_read(32'h0000_0020, d);
        chk("wstrb0_data", d, 32'h1122_AB44);

        // Out-of-range
        do_write(32'h0000_4000, 32'hCAFE_F00D, 4'hF, ce, br);
        chk("oor_w_ce", {31'b0, ce}, 32'd0);
        chk("oor_bresp", {31'b0, br}, 32'd1);
        do_read(32'h0000_4000, d);
        chk("oor_rdata", d, 32'h0);

        // Reset with both responses pending
        @(posedge clk); #1;
        sb_rready = 0; sb_bready = 0;
        sb_arvalid = 1; sb_araddr = 32'h8;
        wait_ar();
        @(posedge clk); #1;
        sb_arvalid = 0; sb_wvalid = 1; sb_waddr = 32'hC; sb_wdata = 32'h5555_AAAA; sb_wstrb = 4'hF;
        @(posedge clk); #1;
        sb_wvalid = 0;
        @(negedge clk);
        chk("pre_rst_rvalid", {31'b0, sb_rvalid}, 32'd1);
        chk("pre_rst_bvalid", {31'b0, sb_bvalid}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("post_rst_rvalid", {31'b0, sb_rvalid}, 32'd0);
        chk("post_rst_bvalid", {31'b0, sb_bvalid}, 32'd0);

        // Random traffic checked by the reference model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            sb_arvalid = ($urandom % 3) != 0;
            sb_araddr  = rand_addr();
            sb_wvalid  = ($urandom % 3) != 0;
            sb_waddr   = rand_addr();
            sb_wdata   = $urandom;
            sb_wstrb   = 4'($urandom);
            sb_rready  = ($urandom % 4) != 0;
            sb_bready  = ($urandom % 4) != 0;
            if ($urandom % 500 == 0) rst = 1; else rst = 0;
        end
        @(posedge clk); #1;
        rst = 0; idle_inputs(); sb_rready = 1; sb_bready = 1;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
